// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes four shadowed BCD digits onto a shared
// 4-digit common-anode 7-segment display (active-low anodes and dp).
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_sel,
  input  logic        load,
  input  logic        disp_en,
  output logic [3:0]  digit_out,
  output logic [3:0]  an,
  output logic        dp,
  output logic        slot_tick
);

  localparam int NUM_DIG = 4;

  logic [CNT_W-1:0]              pre;
  logic                          tick;
  logic [1:0]                    idx;
  logic [NUM_DIG-1:0][3:0]       sh_d;
  logic [NUM_DIG-1:0]            sh_dp;
  logic                          show;

  assign tick = (pre == CNT_W'(REFRESH_DIV - 1));

  // prescaler: one slot every REFRESH_DIV cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  // scan index, natural 2-bit wrap gives 0,1,2,3,0,...
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     idx <= '0;
    else if (tick) idx <= idx + 2'd1;
  end

  // shadow capture so a multi-digit value is never shown half-updated
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_d  <= '0;
      sh_dp <= '0;
    end else if (load) begin
      sh_d  <= digits_in;
      sh_dp <= dp_sel;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // a digit is blank when it and everything left of it is zero with no dp
  // lit at or left of it; digit 0 always shows so "0" is still visible
  logic [NUM_DIG-1:0] blank;
  assign blank[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIG; k++) begin : g_lz
    assign blank[k] = (sh_d[NUM_DIG-1:k] == '0) && (sh_dp[NUM_DIG-1:k] == '0);
  end
  assign show = ~blank[idx];
`else
  assign show = 1'b1;
`endif

  // registered output stage; digit_out keeps tracking even when blanked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_out <= 4'h0;
      an        <= 4'b1111;
      dp        <= 1'b1;
      slot_tick <= 1'b0;
    end else begin
      digit_out <= sh_d[idx];
      slot_tick <= tick;
      if (disp_en && show) begin
        an <= ~(4'b0001 << idx);
        dp <= ~sh_dp[idx];
      end else begin
        an <= 4'b1111;
        dp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed slot checks plus randomized traffic against an
// edge-count based model of the scan.
module tb_seg7_scan_mux;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_sel = 4'h0;
  logic        load = 1'b0;
  logic        disp_en = 1'b1;
  logic [3:0]  digit_out, an;
  logic        dp, slot_tick;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_mux #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_sel(dp_sel),
    .load(load), .disp_en(disp_en), .digit_out(digit_out), .an(an),
    .dp(dp), .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  // model: edges since reset release determine slot; shown slot lags by one
  int          m_k = 0;
  logic [15:0] m_d = 16'h0;
  logic [3:0]  m_p = 4'h0;
  logic [3:0]  e_an = 4'hf, e_dig = 4'h0;
  logic        e_dp = 1'b1, e_st = 1'b0;

  function automatic logic [9:0] model_out(int k, logic [15:0] d, logic [3:0] p, logic en);
    int s;
    logic on;
    logic [3:0] dig;
    s   = (k / DIV) % 4;
    on  = en;
    dig = 4'((d >> (4 * s)) & 16'hf);
`ifdef SEG7_LZ_BLANK_EN
    if (s > 0 && (d >> (4 * s)) == 16'h0 && (p >> s) == 4'h0) on = 1'b0;
`endif
    return {on ? ~(4'b0001 << s) : 4'hf, dig, on ? ~p[s] : 1'b1, (k % DIV) == DIV - 1};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k <= 0;
      m_d <= 16'h0;
      m_p <= 4'h0;
      {e_an, e_dig, e_dp, e_st} <= {4'hf, 4'h0, 1'b1, 1'b0};
    end else begin
      {e_an, e_dig, e_dp, e_st} <= model_out(m_k, m_d, m_p, disp_en);
      m_k <= m_k + 1;
      if (load) begin
        m_d <= digits_in;
        m_p <= dp_sel;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    n_cmp++;
    if ({an, digit_out, dp, slot_tick} !== {e_an, e_dig, e_dp, e_st}) begin
      n_bad++;
      $display("FAIL model t=%0t: an/dig/dp/st got %b/%h/%b/%b want %b/%h/%b/%b",
               $time, an, digit_out, dp, slot_tick, e_an, e_dig, e_dp, e_st);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    digits_in = d;
    dp_sel = p;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("release_an", int'(an), int'(disp_en ? 4'b1110 : 4'b1111));
    check("release_dig", int'(digit_out), 0);
  endtask

  // wait for the next slot_tick, then check the slot shown one cycle later
  task automatic next_slot(input string nm, input logic [3:0] ean, input logic [3:0] edig,
                           input logic edp, input int ewait);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!slot_tick && w < 3 * DIV);
    if (!slot_tick) check({nm, "_timeout"}, 0, 1);
    else if (ewait > 0) check({nm, "_period"}, w, ewait);
    @(negedge clk);
    check({nm, "_an"}, int'(an), int'(ean));
    check({nm, "_dig"}, int'(digit_out), int'(edig));
    check({nm, "_dp"}, int'(dp), int'(edp));
  endtask

  logic [3:0] lz_an [3][4];
  logic [3:0] lz_dg [3][4];
  logic       lz_dp [3][4];
  logic [15:0] lz_d [3];
  logic [3:0]  lz_p [3];

  initial begin
    int off;
    logic [15:0] mask;

    @(negedge clk);
    check("rst_an", int'(an), 4'hf);
    check("rst_dig", int'(digit_out), 0);
    check("rst_dp", int'(dp), 1);
    check("rst_st", int'(slot_tick), 0);

    // basic scan order, slot length and dp position
    do_reset(16'h1234, 4'b0100);
    next_slot("s1", 4'b1101, 4'h3, 1'b1, DIV - 1);
    next_slot("s2", 4'b1011, 4'h2, 1'b0, DIV - 1);
    next_slot("s3", 4'b0111, 4'h1, 1'b1, DIV - 1);
    next_slot("s0", 4'b1110, 4'h4, 1'b1, DIV - 1);
    next_slot("s1b", 4'b1101, 4'h3, 1'b1, DIV - 1);

    // load in the tick cycle takes effect in the very next slot
    repeat (2) @(negedge clk);
    digits_in = 16'h5678;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    digits_in = 16'h9999;
    check("lt_st", int'(slot_tick), 1);
    @(negedge clk);
    check("lt_an", int'(an), 4'b1011);
    check("lt_dig", int'(digit_out), 6);
    next_slot("lt3", 4'b0111, 4'h5, 1'b1, DIV - 1);

    // blanking window does not disturb scan timing
    disp_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("off_an", int'(an), 4'hf);
      check("off_dp", int'(dp), 1);
    end
    disp_en = 1'b1;
    next_slot("on2", 4'b1011, 4'h6, 1'b0, 1);

    // async reset mid slot 2
    #2 reset = 1'b1;
    #1;
    check("ar_an", int'(an), 4'hf);
    check("ar_dig", int'(digit_out), 0);
    check("ar_dp", int'(dp), 1);
    check("ar_st", int'(slot_tick), 0);

    // leading-zero cases; order of slots after release is 1,2,3,0
    lz_d[0] = 16'h0070; lz_p[0] = 4'b0000;
    lz_d[1] = 16'h0000; lz_p[1] = 4'b0000;
    lz_d[2] = 16'h0070; lz_p[2] = 4'b0100;
`ifdef SEG7_LZ_BLANK_EN
    lz_an[0] = '{4'b1101, 4'b1111, 4'b1111, 4'b1110};
    lz_an[1] = '{4'b1111, 4'b1111, 4'b1111, 4'b1110};
    lz_an[2] = '{4'b1101, 4'b1011, 4'b1111, 4'b1110};
`else
    lz_an[0] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    lz_an[1] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    lz_an[2] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
`endif
    lz_dg[0] = '{4'h7, 4'h0, 4'h0, 4'h0};
    lz_dg[1] = '{4'h0, 4'h0, 4'h0, 4'h0};
    lz_dg[2] = '{4'h7, 4'h0, 4'h0, 4'h0};
    lz_dp[0] = '{1'b1, 1'b1, 1'b1, 1'b1};
    lz_dp[1] = '{1'b1, 1'b1, 1'b1, 1'b1};
    lz_dp[2] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 3; c++) begin
      do_reset(lz_d[c], lz_p[c]);
      for (int s = 0; s < 4; s++)
        next_slot($sformatf("lz%0d_%0d", c, (s + 1) % 4), lz_an[c][s], lz_dg[c][s],
                  lz_dp[c][s], DIV - 1);
    end

    // randomized traffic, model checks every cycle
    off = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      case ($urandom_range(3))
        0: mask = 16'hffff;
        1: mask = 16'h00ff;
        2: mask = 16'h000f;
        default: mask = 16'h0000;
      endcase
      digits_in = 16'($urandom) & mask;
      dp_sel = ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0;
      load = ($urandom_range(5) == 0);
      if (off > 0) off--;
      else if ($urandom_range(49) == 0) off = 10;
      disp_en = (off == 0);
      if ($urandom_range(499) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end

    load = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
